ov2640_sccb_sequencer: RTL and testbench

- Power-up and register-load sequencer for the OV2640 camera.
- Drives sensor PWDN/RESETB through the datasheet power-on order.
- Then walks a synchronous config ROM of {reg, value} words and issues one SCCB write per entry to an external byte-level SCCB master via a start/busy/done handshake.
- Supports delay and end markers in the ROM, NACK retry, and a `resend` re-load. `config_finished` gates the downstream capture/HDMI path.

---
 rtl/ov2640_sccb_sequencer_if.sv | 20 ++
 rtl/ov2640_sccb_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ov2640_sccb_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ov2640_sccb_sequencer_if.sv
// Byte-level SCCB write handshake between the OV2640 config sequencer and the SCCB master.
interface ov2640_sccb_sequencer_if;
  logic       sccb_start;
  logic [7:0] sccb_id;
  logic [7:0] sccb_reg;
  logic [7:0] sccb_val;
  logic       sccb_busy;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (
    output sccb_start, sccb_id, sccb_reg, sccb_val,
    input  sccb_busy, sccb_done, sccb_nack
  );

  modport slave (
    input  sccb_start, sccb_id, sccb_reg, sccb_val,
    output sccb_busy, sccb_done, sccb_nack
  );
endinterface

// File: rtl/ov2640_sccb_sequencer.sv
// OV2640 power-up sequencer and config-ROM loader: PWDN/RESETB ordering, then one SCCB
// write per ROM entry with delay/end markers, NACK retry and resend-triggered reload.
module ov2640_sccb_sequencer #(
  parameter logic [7:0]  DEV_ID            = 8'h60,
  parameter int unsigned ROM_AW            = 8,
  parameter int unsigned PWDN_CYCLES       = 270000,
  parameter int unsigned RESET_CYCLES      = 270000,
  parameter int unsigned BOOT_CYCLES       = 27000,
  parameter int unsigned DELAY_UNIT_CYCLES = 27000,
  parameter int unsigned MAX_RETRY         = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_resend,
  output logic [ROM_AW-1:0]         o_rom_addr,
  input  logic [15:0]               i_rom_data,
  ov2640_sccb_sequencer_if.master   sccb,
  output logic                      o_cam_pwdn,
  output logic                      o_cam_reset_n,
  output logic                      o_config_finished,
  output logic                      o_config_error
);

  localparam int unsigned DLY_W  = $clog2(255 * DELAY_UNIT_CYCLES + 1);
  localparam int unsigned PWR_MX = (PWDN_CYCLES > RESET_CYCLES) ?
                                   ((PWDN_CYCLES > BOOT_CYCLES) ? PWDN_CYCLES : BOOT_CYCLES) :
                                   ((RESET_CYCLES > BOOT_CYCLES) ? RESET_CYCLES : BOOT_CYCLES);
  localparam int unsigned PWR_W  = $clog2(PWR_MX + 1);
  localparam int unsigned CNT_W  = (DLY_W > PWR_W) ? DLY_W : PWR_W;
  localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_PWR_DOWN, S_RST_HOLD, S_BOOT, S_FETCH, S_DECODE, S_ISSUE,
    S_WAIT_DONE, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [RTY_W-1:0]    r_retry;
  logic [ROM_AW-1:0]   r_rom_addr;
  logic                r_start;
  logic [7:0]          r_reg;
  logic [7:0]          r_val;
  logic                r_cam_pwdn;
  logic                r_cam_reset_n;
  logic                r_finished;
  logic                r_error;

  assign o_rom_addr        = r_rom_addr;
  assign o_cam_pwdn        = r_cam_pwdn;
  assign o_cam_reset_n     = r_cam_reset_n;
  assign o_config_finished = r_finished;
  assign o_config_error    = r_error;
  assign sccb.sccb_start   = r_start;
  assign sccb.sccb_id      = DEV_ID;
  assign sccb.sccb_reg     = r_reg;
  assign sccb.sccb_val     = r_val;

  // Single sequencer FSM; r_cnt is shared by the power timers and the delay marker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_PWR_DOWN;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_rom_addr    <= '0;
      r_start       <= 1'b0;
      r_reg         <= '0;
      r_val         <= '0;
      r_cam_pwdn    <= 1'b1;
      r_cam_reset_n <= 1'b0;
      r_finished    <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_PWR_DOWN: begin
          if (r_cnt == CNT_W'(PWDN_CYCLES - 1)) begin
            r_cnt      <= '0;
            r_cam_pwdn <= 1'b0;
            r_state    <= S_RST_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RST_HOLD: begin
          if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            r_cnt         <= '0;
            r_cam_reset_n <= 1'b1;
            r_state       <= S_BOOT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BOOT: begin
          if (r_cnt == CNT_W'(BOOT_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // ROM output lands one cycle after the address; DECODE sees it registered.
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == 16'hFFFF) begin
            r_finished <= 1'b1;
            r_state    <= S_DONE;
          end else if (i_rom_data[15:8] == 8'hFE) begin
            r_cnt   <= CNT_W'(i_rom_data[7:0]) * CNT_W'(DELAY_UNIT_CYCLES);
            r_state <= S_DELAY;
          end else begin
            r_reg   <= i_rom_data[15:8];
            r_val   <= i_rom_data[7:0];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!sccb.sccb_busy) begin
            r_start <= 1'b1;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (sccb.sccb_done) begin
            if (!sccb.sccb_nack) begin
              r_retry <= '0;
              r_state <= S_NEXT;
            end else if (r_retry < RTY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + RTY_W'(1);
              r_state <= S_ISSUE;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == '0) r_state <= S_NEXT;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        // Last ROM slot acts as an implicit end marker rather than wrapping.
        S_NEXT: begin
          if (r_rom_addr == {ROM_AW{1'b1}}) begin
            r_finished <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_rom_addr <= r_rom_addr + ROM_AW'(1);
            r_state    <= S_FETCH;
          end
        end
        S_DONE, S_ERROR: begin
          if (i_resend) begin
            r_finished <= 1'b0;
            r_error    <= 1'b0;
            r_rom_addr <= '0;
            r_retry    <= '0;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_PWR_DOWN;
      endcase
    end
  end

endmodule

// File: tb/tb_ov2640_sccb_sequencer.sv
// Scoreboard bench for ov2640_sccb_sequencer: expected SCCB writes are queued by the
// stimulus thread and popped by a monitor on every sccb_start.
module tb_ov2640_sccb_sequencer;

  logic        clk;
  logic        rst;
  logic        resend;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        pwdn, reset_n, fin, err;
  logic [15:0] rom [16];

  ov2640_sccb_sequencer_if bus ();

  ov2640_sccb_sequencer #(
    .DEV_ID(8'h60), .ROM_AW(4), .PWDN_CYCLES(4), .RESET_CYCLES(4),
    .BOOT_CYCLES(4), .DELAY_UNIT_CYCLES(8), .MAX_RETRY(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_resend(resend),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .sccb(bus),
    .o_cam_pwdn(pwdn), .o_cam_reset_n(reset_n),
    .o_config_finished(fin), .o_config_error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Synchronous config ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Behavioural SCCB master: busy 20 cycles after start, then done (+ scripted NACKs).
  logic [7:0] nack_reg;
  int nack_n, nack_base;
  int nack_seen = 0;
  int bcnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.sccb_busy <= 1'b0;
      bus.sccb_done <= 1'b0;
      bus.sccb_nack <= 1'b0;
      bcnt          <= 0;
    end else begin
      bus.sccb_done <= 1'b0;
      bus.sccb_nack <= 1'b0;
      if (bus.sccb_start) begin
        bus.sccb_busy <= 1'b1;
        bcnt          <= 20;
      end else if (bus.sccb_busy) begin
        if (bcnt == 1) begin
          bus.sccb_busy <= 1'b0;
          bus.sccb_done <= 1'b1;
          if (bus.sccb_reg == nack_reg && (nack_seen - nack_base) < nack_n) begin
            bus.sccb_nack <= 1'b1;
            nack_seen     <= nack_seen + 1;
          end
        end else begin
          bcnt <= bcnt - 1;
        end
      end
    end
  end

  // Scoreboard monitor
  logic [15:0] exp_q [$];
  logic [15:0] cur_wr = 16'h0;
  int last_done_cyc = 0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst) begin
      if (bus.sccb_start) begin
        check("start_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_regval", 32'({bus.sccb_reg, bus.sccb_val}), 32'(e));
        end
        cur_wr = {bus.sccb_reg, bus.sccb_val};
      end
      if (bus.sccb_done) begin
        check("hold_regval", 32'({bus.sccb_reg, bus.sccb_val}), 32'(cur_wr));
        last_done_cyc = cyc;
      end
    end
  end

  // Enters with rst already high; checks reset values, releases, checks power order.
  task automatic power_up();
    logic [2:0] exp3;
    @(posedge clk);
    @(negedge clk);
    check("reset_vals", 32'({pwdn, reset_n, bus.sccb_start, bus.sccb_reg, bus.sccb_val, rom_addr, fin, err}),
          32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0}));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp3 = (i < 4) ? 3'b100 : ((i < 8) ? 3'b000 : 3'b010);
      check("pwr_seq", 32'({pwdn, reset_n, bus.sccb_start}), 32'(exp3));
    end
    @(negedge clk);
    check("first_fetch_addr", 32'(rom_addr), 32'd0);
  endtask

  task automatic pulse_resend();
    @(posedge clk);
    #1 resend = 1'b1;
    @(posedge clk);
    #1 resend = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int end_cyc, output bit pwr_seen);
    pwr_seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (pwdn || !reset_n) pwr_seen = 1'b1;
      if (fin || err) break;
    end
    end_cyc = cyc;
    check("end_reached", 32'(fin | err), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.sccb_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic load_basic_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'hFF00;
    rom[1] = 16'h1280;
    rom[2] = 16'hFE03;
    rom[3] = 16'hFFFF;
  endtask

  int  end_c;
  bit  pw;

  initial begin
    rst       = 1'b1;
    resend    = 1'b0;
    nack_reg  = 8'h00;
    nack_n    = 0;
    nack_base = 0;
    load_basic_rom();

    // Power-up sequence and basic load with delay marker
    power_up();
    check("dev_id", 32'(bus.sccb_id), 32'h60);
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h1280);
    wait_end(2000, end_c, pw);
    check("load_flags", 32'({fin, err}), 32'b10);
    check("load_q_empty", 32'(exp_q.size()), 32'd0);
    check("delay_gap_ge24", 32'((end_c - last_done_cyc) >= 24), 32'd1);

    // Resend from DONE with two NACKs on 0x12
    nack_reg  = 8'h12;
    nack_base = nack_seen;
    nack_n    = 2;
    exp_q.push_back(16'hFF00);
    repeat (3) exp_q.push_back(16'h1280);
    pulse_resend();
    wait_end(2000, end_c, pw);
    check("retry_flags", 32'({fin, err}), 32'b10);
    check("retry_q_empty", 32'(exp_q.size()), 32'd0);
    check("retry_no_pwr_pulse", 32'(pw), 32'd0);

    // Retry exhaustion
    nack_base = nack_seen;
    nack_n    = 1000;
    exp_q.push_back(16'hFF00);
    repeat (3) exp_q.push_back(16'h1280);
    pulse_resend();
    wait_end(2000, end_c, pw);
    check("exhaust_flags", 32'({fin, err}), 32'b01);
    check("exhaust_q_empty", 32'(exp_q.size()), 32'd0);
    nack_n = 0;

    // Resend from ERROR, then an ignored mid-load resend
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h1280);
    pulse_resend();
    check("err_clear", 32'({fin, err, rom_addr}), 32'd0);
    wait_start(200);
    pulse_resend();
    wait_end(2000, end_c, pw);
    check("midresend_flags", 32'({fin, err}), 32'b10);
    check("midresend_q_empty", 32'(exp_q.size()), 32'd0);
    check("midresend_no_pwr_pulse", 32'(pw), 32'd0);

    // Reset during WAIT_DONE restarts the full power sequence
    exp_q.push_back(16'hFF00);
    pulse_resend();
    wait_start(200);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h1280);
    power_up();
    wait_end(2000, end_c, pw);
    check("rst_reload_flags", 32'({fin, err}), 32'b10);
    check("rst_reload_q_empty", 32'(exp_q.size()), 32'd0);

    // Full ROM with no end marker: 16 writes, stop at last address
    for (int i = 0; i < 16; i++) begin
      rom[i] = {8'(32'h20 + i), 8'(32'h40 + i)};
      exp_q.push_back({8'(32'h20 + i), 8'(32'h40 + i)});
    end
    pulse_resend();
    wait_end(3000, end_c, pw);
    check("full_flags", 32'({fin, err}), 32'b10);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
    check("full_last_addr", 32'(rom_addr), 32'd15);
    repeat (5) @(negedge clk);
    check("full_addr_held", 32'({fin, rom_addr}), 32'h1F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
